nec_prefetch: RTL

Instruction prefetch unit for the NEC core. It fills the 8-byte instruction prefetch queue (ipq) that the decode stage reads, using 16-bit code fetches over the core bus at physical address {ps,4'h0}+fetch_ip. Each byte is stored at queue index = its logical address[2:0], so the decoder reads ipq[pc[2:0]+ofs] directly. On a branch (set_pc) the queue is flushed and refilled from new_pc.

---
 rtl/nec_prefetch_if.sv | 19 +
 rtl/nec_prefetch.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/nec_prefetch_if.sv
// Core-bus code-fetch channel between the NEC prefetch unit (master) and the bus unit (slave).
interface nec_prefetch_if;
    logic        bus_req;
    logic [19:0] bus_addr;
    logic        bus_byte;
    logic        bus_ack;
    logic        bus_valid;
    logic [15:0] bus_data;

    modport master (
        output bus_req, bus_addr, bus_byte,
        input  bus_ack, bus_valid, bus_data
    );

    modport slave (
        input  bus_req, bus_addr, bus_byte,
        output bus_ack, bus_valid, bus_data
    );
endinterface

// File: rtl/nec_prefetch.sv
// NEC instruction prefetch unit: fills the 8-byte address-indexed queue with 16-bit code fetches.
// Define PREFETCH_FLUSH_ABORT_EN to abandon a not-yet-acknowledged request on flush.
module nec_prefetch #(
    parameter int QUEUE_SIZE = 8,
    parameter int MIN_FREE   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce_1,
    input  logic [15:0]        ps,
    input  logic [15:0]        decode_pc,
    input  logic               set_pc,
    input  logic [15:0]        new_pc,
    input  logic               block_prefetch,
    output logic [7:0]         ipq [QUEUE_SIZE],
    output logic [3:0]         ipq_len,
    output logic [15:0]        fetch_ip,
    nec_prefetch_if.master     bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic        discard_r, discard_s;
    logic [15:0] fetch_ip_r, fetch_ip_s;
    logic        bus_req_r, bus_req_s;
    logic [19:0] bus_addr_r, bus_addr_s;
    logic        bus_byte_r, bus_byte_s;
    logic        data_done_s;
    logic        wr_en_s;
    logic [15:0] diff_s;
    logic [3:0]  ipq_len_s;
    logic [3:0]  free_s;
    logic        can_issue_s;
    logic [2:0]  idx_s;
    logic [2:0]  idx_p1_s;

    assign bus.bus_req  = bus_req_r;
    assign bus.bus_addr = bus_addr_r;
    assign bus.bus_byte = bus_byte_r;
    assign fetch_ip     = fetch_ip_r;
    assign ipq_len      = ipq_len_s;

    // Queue occupancy seen from the decoder's pc; an odd fetch address needs only one free slot.
    always_comb begin
        diff_s    = fetch_ip_r - decode_pc;
        ipq_len_s = (diff_s > 16'd8) ? 4'd8 : diff_s[3:0];
        free_s    = 4'(QUEUE_SIZE) - ipq_len_s;
        if (fetch_ip_r[0]) begin
            can_issue_s = (free_s >= 4'd1);
        end else begin
            can_issue_s = (free_s >= 4'(MIN_FREE));
        end
        idx_s    = fetch_ip_r[2:0];
        idx_p1_s = fetch_ip_r[2:0] + 3'd1;
    end

    // Next-state and bus-output logic; flush always wins over returning data.
    always_comb begin
        state_s     = state_r;
        discard_s   = discard_r;
        fetch_ip_s  = fetch_ip_r;
        bus_req_s   = bus_req_r;
        bus_addr_s  = bus_addr_r;
        bus_byte_s  = bus_byte_r;
        data_done_s = 1'b0;
        wr_en_s     = 1'b0;

        case (state_r)
            IDLE: begin
                if (!set_pc && !block_prefetch && can_issue_s) begin
                    state_s    = REQ;
                    bus_req_s  = 1'b1;
                    bus_addr_s = {ps, 4'h0} + {4'h0, fetch_ip_r};
                    bus_byte_s = fetch_ip_r[0];
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (bus.bus_ack) begin
                    bus_req_s = 1'b0;
                    if (bus.bus_valid) begin
                        data_done_s = 1'b1;
                    end else begin
                        state_s   = WAIT;
                        discard_s = discard_r | set_pc;
                    end
                end else if (set_pc) begin
`ifdef PREFETCH_FLUSH_ABORT_EN
                    bus_req_s = 1'b0;
                    state_s   = IDLE;
                    discard_s = 1'b0;
`else
                    discard_s = 1'b1;
`endif
                end else begin
                    state_s = REQ;
                end
            end
            WAIT: begin
                if (bus.bus_valid) begin
                    data_done_s = 1'b1;
                end else if (set_pc) begin
                    discard_s = 1'b1;
                end else begin
                    state_s = WAIT;
                end
            end
            default: begin
                state_s   = IDLE;
                bus_req_s = 1'b0;
                discard_s = 1'b0;
            end
        endcase

        if (data_done_s) begin
            state_s   = IDLE;
            discard_s = 1'b0;
            wr_en_s   = !discard_r && !set_pc;
        end else begin
            wr_en_s = 1'b0;
        end

        if (set_pc) begin
            fetch_ip_s = new_pc;
        end else if (wr_en_s) begin
            fetch_ip_s = fetch_ip_r + (bus_byte_r ? 16'd1 : 16'd2);
        end else begin
            fetch_ip_s = fetch_ip_r;
        end
    end

    // State and queue registers, advancing only on phase-1 enables.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            discard_r  <= 1'b0;
            fetch_ip_r <= 16'h0000;
            bus_req_r  <= 1'b0;
            bus_addr_r <= 20'h00000;
            bus_byte_r <= 1'b0;
            for (int i = 0; i < QUEUE_SIZE; i++) begin
                ipq[i] <= 8'h00;
            end
        end else if (ce_1) begin
            state_r    <= state_s;
            discard_r  <= discard_s;
            fetch_ip_r <= fetch_ip_s;
            bus_req_r  <= bus_req_s;
            bus_addr_r <= bus_addr_s;
            bus_byte_r <= bus_byte_s;
            if (wr_en_s) begin
                // An odd-byte fetch returns its byte on the high lane.
                if (bus_byte_r) begin
                    ipq[idx_s] <= bus.bus_data[15:8];
                end else begin
                    ipq[idx_s]    <= bus.bus_data[7:0];
                    ipq[idx_p1_s] <= bus.bus_data[15:8];
                end
            end
        end
    end

endmodule
